// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: mode-0 SPI master that reads a 5-byte frame every frame period,
// then turns each axis into left/right/up/down pulses with hold-to-repeat.

module jstk_axis_repeat #(
   parameter int LOW_TH       = 300,
   parameter int HIGH_TH      = 700,
   parameter int REPEAT_FIRST = 30,
   parameter int REPEAT_NEXT  = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       frame_i,
   input  logic [9:0] value_i,
   output logic       neg_o,
   output logic       pos_o
);
   typedef enum logic [1:0] {AX_NEUTRAL = 2'd0, AX_NEG = 2'd1, AX_POS = 2'd2} axis_t;
   localparam int RW = $clog2(REPEAT_FIRST + REPEAT_NEXT + 1);
   localparam logic [9:0]    LOW_V  = 10'(LOW_TH);
   localparam logic [9:0]    HIGH_V = 10'(HIGH_TH);
   localparam logic [RW-1:0] FIRST_V = RW'(REPEAT_FIRST);
   localparam logic [RW-1:0] NEXT_V  = RW'(REPEAT_NEXT);
   localparam logic [RW-1:0] ONE_V   = RW'(1);

   axis_t         state_q, state_d, want_s;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          fire_s, neg_s, pos_s, neg_d, pos_d, neg_q, pos_q;

   assign neg_s  = (value_i < LOW_V);
   assign pos_s  = (value_i > HIGH_V);
   assign want_s = neg_s ? AX_NEG : AX_POS;
   assign neg_o  = neg_q;
   assign pos_o  = pos_q;

   // State, repeat counter and pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= AX_NEUTRAL;
         rcnt_q  <= {RW{1'b0}};
         neg_q   <= 1'b0;
         pos_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         neg_q   <= neg_d;
         pos_q   <= pos_d;
      end
   end

   // Per-frame decision: a new or reversed deflection fires at once, a held one on countdown
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire_s  = 1'b0;
      if (!frame_i) begin
         state_d = state_q;
      end else if (!neg_s && !pos_s) begin
         state_d = AX_NEUTRAL;
      end else if (state_q != want_s) begin
         state_d = want_s;
         rcnt_d  = FIRST_V;
         fire_s  = 1'b1;
      end else if (rcnt_q == ONE_V) begin
         rcnt_d  = NEXT_V;
         fire_s  = 1'b1;
      end else begin
         rcnt_d  = rcnt_q - ONE_V;
      end
   end

   // Pulse outputs
   always_comb begin
      neg_d = fire_s && (state_d == AX_NEG);
      pos_d = fire_s && (state_d == AX_POS);
   end
endmodule

module jstk_spi_reader #(
   parameter int CLK_HALF     = 100,
   parameter int BYTE_GAP     = 1500,
   parameter int FRAME_GAP    = 1_000_000,
   parameter int LOW_TH       = 300,
   parameter int HIGH_TH      = 700,
   parameter int REPEAT_FIRST = 30,
   parameter int REPEAT_NEXT  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       MISO,
   output logic       SS,
   output logic       MOSI,
   output logic       SCLK,
   output logic       left,
   output logic       right,
   output logic       up,
   output logic       down,
   output logic       click,
   output logic       down_click,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       sample_valid
);
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_SETUP = 3'd1, ST_SHIFT = 3'd2, ST_GAP = 3'd3, ST_DONE = 3'd4
   } state_t;

   localparam int CNT_W = $clog2(FRAME_GAP + BYTE_GAP + 2 * CLK_HALF + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_GAP - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(BYTE_GAP - 1);
   localparam logic [CNT_W-1:0] HALF_V    = CNT_W'(CLK_HALF);
   localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLK_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(2 * CLK_HALF - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d, byte_q, byte_d;
   logic             sample_s, ss_d, sclk_d, mosi_d;
   logic [7:0]       cmd_s, rx_byte_s, x_lo_q, y_lo_q;
   logic [6:0]       rx_q;
   logic [1:0]       x_hi_q, y_hi_q, btn_q;
   logic             ss_q, sclk_q, mosi_q, valid_q, click_q, down_click_q;
   logic [9:0]       x_pos_q, y_pos_q;

   assign rx_byte_s    = {rx_q, MISO};
   assign SS           = ss_q;
   assign SCLK         = sclk_q;
   assign MOSI         = mosi_q;
   assign sample_valid = valid_q;
   assign click        = click_q;
   assign down_click   = down_click_q;
   assign x_pos        = x_pos_q;
   assign y_pos        = y_pos_q;

   // Transaction state and timing counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         bit_q   <= 3'd7;
         byte_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
      end
   end

   // Next state; cnt counts clocks within the current state (or within one bit in SHIFT)
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_ONE;
      bit_d    = bit_q;
      byte_d   = byte_q;
      sample_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q == FRAME_END) begin
               state_d = ST_SETUP;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP, ST_GAP: begin
            if (cnt_q == GAP_END) begin
               state_d = ST_SHIFT;
               cnt_d   = {CNT_W{1'b0}};
               bit_d   = 3'd7;
               byte_d  = (state_q == ST_SETUP) ? 3'd0 : byte_q + 3'd1;
            end else begin
               state_d = state_q;
            end
         end
         ST_SHIFT: begin
            sample_s = (cnt_q == HALF_END);
            if (cnt_q != BIT_END) begin
               state_d = ST_SHIFT;
            end else if (bit_q != 3'd0) begin
               cnt_d = {CNT_W{1'b0}};
               bit_d = bit_q - 3'd1;
            end else begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = (byte_q == 3'd4) ? ST_DONE : ST_GAP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Pin values for the upcoming state, so SS/SCLK/MOSI can be registered without lag
   always_comb begin
      ss_d   = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      cmd_s  = (byte_d == 3'd0) ? 8'h80 : 8'h00;
      case (state_d)
         ST_SETUP, ST_GAP: ss_d = 1'b0;
         ST_SHIFT: begin
            ss_d   = 1'b0;
            sclk_d = (cnt_d >= HALF_V);
            mosi_d = cmd_s[bit_d];
         end
         default: ss_d = 1'b1;
      endcase
   end

   // Pins, receive shifter and captured frame
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_q         <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         valid_q      <= 1'b0;
         rx_q         <= 7'd0;
         x_lo_q       <= 8'd0;
         y_lo_q       <= 8'd0;
         x_hi_q       <= 2'd0;
         y_hi_q       <= 2'd0;
         btn_q        <= 2'd0;
         x_pos_q      <= 10'd512;
         y_pos_q      <= 10'd512;
         click_q      <= 1'b0;
         down_click_q <= 1'b0;
      end else begin
         ss_q    <= ss_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         valid_q <= (state_d == ST_DONE);
         if (sample_s) begin
            rx_q <= rx_byte_s[6:0];
            if (bit_q == 3'd0) begin
               case (byte_q)
                  3'd0:    x_lo_q <= rx_byte_s;
                  3'd1:    x_hi_q <= rx_byte_s[1:0];
                  3'd2:    y_lo_q <= rx_byte_s;
                  3'd3:    y_hi_q <= rx_byte_s[1:0];
                  default: btn_q  <= rx_byte_s[1:0];
               endcase
            end
         end
         if (state_d == ST_DONE) begin
            x_pos_q      <= {x_hi_q, x_lo_q};
            y_pos_q      <= {y_hi_q, y_lo_q};
            click_q      <= btn_q[0];
            down_click_q <= btn_q[1];
         end
      end
   end

   jstk_axis_repeat #(
      .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .REPEAT_FIRST(REPEAT_FIRST), .REPEAT_NEXT(REPEAT_NEXT)
   ) u_x_axis (
      .clk_i(clk), .rst_i(rst), .frame_i(valid_q), .value_i(x_pos_q), .neg_o(left), .pos_o(right)
   );

   jstk_axis_repeat #(
      .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .REPEAT_FIRST(REPEAT_FIRST), .REPEAT_NEXT(REPEAT_NEXT)
   ) u_y_axis (
      .clk_i(clk), .rst_i(rst), .frame_i(valid_q), .value_i(y_pos_q), .neg_o(down), .pos_o(up)
   );
endmodule
